// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-enabled synchronous word RAM with one-cycle read
// latency, address-window checking, saturating access counters and a selectable
// read-during-write policy.
module data_sram_responder #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        oob_err,
    output logic [15:0] wr_count,
    output logic [15:0] oob_count
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [15:0] SAT = 16'hFFFF;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          in_win;
    logic          access;
    logic [31:0]   old_word;
    logic [31:0]   merged_word;
    logic          unused_byte_offset;

    // The window test runs on the rebased offset, so an address below
    // BASE_ADDR wraps to a huge offset and is rejected like one above the top.
    assign offset             = data_sram_addr - BASE_ADDR;
    assign idx                = offset[AW+1:2];
    assign in_win             = (offset[31:AW+2] == '0);
    assign access             = data_sram_en && in_win;
    assign unused_byte_offset = ^offset[1:0];

    // NOTE: every variable driven here gets a value before any condition,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        old_word    = mem[idx];
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
        end
    end

    // NOTE: the array has no reset branch on purpose: contents survive reset,
    // and a reset-free byte-enabled write maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && access) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= '0;
            oob_err         <= 1'b0;
            wr_count        <= '0;
            oob_count       <= '0;
        end else if (data_sram_en) begin
            if (in_win) begin
                data_sram_rdata <= WRITE_FIRST ? merged_word : old_word;
                oob_err         <= 1'b0;
                if ((data_sram_wen != 4'h0) && (wr_count != SAT)) wr_count <= wr_count + 16'd1;
            end else begin
                data_sram_rdata <= '0;
                oob_err         <= 1'b1;
                if (oob_count != SAT) oob_count <= oob_count + 16'd1;
            end
        end else begin
            oob_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a read-first and a write-first instance (the
// latter rebased) driven in lockstep, checked by vector table and random model.
module tb_data_sram_responder;

    localparam logic [31:0] BASE1 = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] addr1;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        oob0, oob1;
    logic [15:0] wrc0, wrc1, oobc0, oobc1;

    assign addr1 = addr + BASE1;

    always #5 clk = ~clk;

    data_sram_responder #(.AW(10), .BASE_ADDR(32'h0), .WRITE_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata0),
        .oob_err(oob0), .wr_count(wrc0), .oob_count(oobc0));

    data_sram_responder #(.AW(10), .BASE_ADDR(BASE1), .WRITE_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr1), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
        .oob_err(oob1), .wr_count(wrc1), .oob_count(oobc1));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain word array indexed by byte offset / 4.
    logic [31:0] m_mem [1024];
    logic [31:0] m_rd_old, m_rd_new;
    logic        m_oob;
    int          m_wrc, m_oobc;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input logic [3:0] we,
                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] old_w, new_w;
        int w;
        if (r) begin
            m_rd_old = 0; m_rd_new = 0; m_oob = 0; m_wrc = 0; m_oobc = 0;
        end else if (!e) begin
            m_oob = 0;
        end else if (a < 32'd4096) begin
            w = int'(a / 4);
            old_w = m_mem[w];
            new_w = old_w;
            for (int b = 0; b < 4; b++) if (we[b]) new_w[8*b +: 8] = wd[8*b +: 8];
            m_mem[w] = new_w;
            m_rd_old = old_w;
            m_rd_new = new_w;
            m_oob = 0;
            if (we != 0 && m_wrc < 65535) m_wrc++;
        end else begin
            m_rd_old = 0; m_rd_new = 0; m_oob = 1;
            if (m_oobc < 65535) m_oobc++;
        end
    endtask

    // Drive one cycle's inputs, let the edge pass, update the model; outputs
    // are then sampled 1 ns after the edge.
    task automatic apply(input bit r, input bit e, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] wd);
        reset = r; en = e; wen = we; addr = a; wdata = wd;
        @(posedge clk);
        model_update(r, e, we, a, wd);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rdata0"}, rdata0, m_rd_old);
        check({tag, " rdata1"}, rdata1, m_rd_new);
        check({tag, " oob0"}, {31'b0, oob0}, {31'b0, m_oob});
        check({tag, " oob1"}, {31'b0, oob1}, {31'b0, m_oob});
        check({tag, " wr_count0"}, {16'b0, wrc0}, m_wrc);
        check({tag, " wr_count1"}, {16'b0, wrc1}, m_wrc);
        check({tag, " oob_count0"}, {16'b0, oobc0}, m_oobc);
        check({tag, " oob_count1"}, {16'b0, oobc1}, m_oobc);
    endtask

    task automatic step(input string tag, input bit r, input bit e, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] wd);
        apply(r, e, we, a, wd);
        check_model(tag);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [3:0]  rw;
        bit          re;

        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        apply(1, 0, 4'h0, 32'h0, 32'h0);
        apply(1, 1, 4'hF, 32'h0, 32'h1234_5678);
        check("reset rdata0", rdata0, 32'h0);
        check("reset rdata1", rdata1, 32'h0);
        check("reset oob_err", {31'b0, oob0}, 32'h0);
        check("reset wr_count", {16'b0, wrc0}, 32'h0);
        check("reset oob_count", {16'b0, oobc0}, 32'h0);

        // Write then read back on the next cycle.
        apply(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        check("t1 wf rdata on write", rdata1, 32'hDEAD_BEEF);
        apply(0, 1, 4'h0, 32'h10, 32'h0);
        check("t1 read rdata0", rdata0, 32'hDEAD_BEEF);
        check("t1 read rdata1", rdata1, 32'hDEAD_BEEF);
        check("t1 wr_count", {16'b0, wrc0}, 32'd1);

        // Fill every word with a known pattern so all later reads are defined.
        for (int i = 0; i < 1024; i++) apply(0, 1, 4'hF, 32'(i * 4), 32'hC0DE_0000 | 32'(i));
        check_model("fill");

        vecs = '{
            '{1, 4'hF, 32'h20,        32'h1122_3344, 32'hC0DE_0008, 32'h1122_3344, 0},
            '{1, 4'h5, 32'h20,        32'hAABB_CCDD, 32'h1122_3344, 32'h11BB_33DD, 0},
            '{1, 4'h0, 32'h20,        32'h0,         32'h11BB_33DD, 32'h11BB_33DD, 0},
            '{1, 4'hF, 32'h30,        32'h1,         32'hC0DE_000C, 32'h1,         0},
            '{1, 4'hF, 32'h30,        32'h2,         32'h1,         32'h2,         0},
            '{1, 4'h0, 32'h30,        32'h0,         32'h2,         32'h2,         0},
            '{1, 4'hF, 32'h1000,      32'hFFFF_FFFF, 32'h0,         32'h0,         1},
            '{1, 4'h0, 32'h0,         32'h0,         32'hC0DE_0000, 32'hC0DE_0000, 0},
            '{0, 4'h0, 32'h0,         32'h0,         32'hC0DE_0000, 32'hC0DE_0000, 0},
            '{1, 4'hF, 32'h44,        32'h5A5A_5A5A, 32'hC0DE_0011, 32'h5A5A_5A5A, 0},
            '{1, 4'h0, 32'h47,        32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A, 0},
            '{0, 4'hF, 32'h44,        32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A, 0},
            '{0, 4'h0, 32'h1000,      32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A, 0},
            '{0, 4'h0, 32'h0,         32'h0,         32'h5A5A_5A5A, 32'h5A5A_5A5A, 0},
            '{1, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0,         1},
            '{0, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0,         0},
            '{1, 4'h0, 32'hFFC,       32'h0,         32'hC0DE_03FF, 32'hC0DE_03FF, 0}
        };
        foreach (vecs[k]) begin
            apply(0, vecs[k].en, vecs[k].wen, vecs[k].addr, vecs[k].wdata);
            check($sformatf("vec%0d rdata0", k), rdata0, vecs[k].exp_rd0);
            check($sformatf("vec%0d rdata1", k), rdata1, vecs[k].exp_rd1);
            check($sformatf("vec%0d oob0", k), {31'b0, oob0}, {31'b0, vecs[k].exp_oob});
            check($sformatf("vec%0d oob1", k), {31'b0, oob1}, {31'b0, vecs[k].exp_oob});
        end
        check("vec oob_count", {16'b0, oobc0}, 32'd2);
        check_model("vec end");

        // Randomised traffic, mostly in-window with occasional wild addresses.
        for (int i = 0; i < 2000; i++) begin
            re = ($urandom_range(0, 9) < 8);
            rw = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            rd = $urandom;
            step("rand", 0, re, rw, ra, rd);
        end

        // Reset mid-stream: the write in the reset cycle must not land.
        step("t6 pre", 0, 1, 4'hF, 32'h40, 32'h7);
        step("t6 rst", 1, 1, 4'hF, 32'h40, 32'h99);
        step("t6 post", 0, 1, 4'h0, 32'h40, 32'h0);
        check("t6 read after reset", rdata0, 32'h7);
        check("t6 wr_count after reset", {16'b0, wrc0}, 32'h0);

        // Drive wr_count to saturation and one write past it.
        for (int i = 0; i < 65535; i++) apply(0, 1, 4'($urandom_range(1, 15)),
                                               32'($urandom_range(0, 4095)), $urandom);
        check("sat wr_count at max", {16'b0, wrc0}, 32'h0000_FFFF);
        step("sat extra", 0, 1, 4'hF, 32'h8, 32'h0BAD_F00D);
        check("sat wr_count held0", {16'b0, wrc0}, 32'h0000_FFFF);
        check("sat wr_count held1", {16'b0, wrc1}, 32'h0000_FFFF);
        step("sat read", 0, 1, 4'h0, 32'h8, 32'h0);
        check("sat read data", rdata0, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
